mips32_mem_responder: RTL and testbench

- Word-addressed data-memory responder: the slave end of the processor's load/store memory interface.
- Accepts one read or write request at a time over a valid/ready request channel.
- Inserts a programmable number of wait states, then returns read data and status over a valid/ready response channel.
- Lets the pipeline's LW/SW traffic move from an internal array to a separate, stallable memory block.

---
 rtl/mips32_mem_responder_if.sv | 24 ++
 rtl/mips32_mem_responder.sv | 105 ++++++++++
 tb/tb_mips32_mem_responder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips32_mem_responder_if.sv
// Load/store memory channel between the processor pipeline and the data-memory responder.
interface mips32_mem_responder_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mips32_mem_responder.sv
// Word-addressed data memory serving one LW/SW at a time, with fixed wait states
// between acceptance and access and a held response until the requester takes it.
module mips32_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  mips32_mem_responder_if.slave  bus,
  output logic                   busy
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic              w_in_range;
  logic              w_access;
  logic [AW-1:0]     w_idx;

  logic [DATA_W-1:0] mem [DEPTH];

  // Full 32-bit compare so nonzero upper address bits never alias into the array.
  assign w_in_range = (r_addr < 32'(DEPTH));
  assign w_idx      = r_addr[AW-1:0];
  assign w_access   = (r_state == S_WAIT) && (r_cnt == 4'd0);

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
  assign busy          = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.req_valid)  w_state_nxt = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0)  w_state_nxt = S_RESP;
      S_RESP:  if (bus.rsp_ready)  w_state_nxt = S_IDLE;
      default:                     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_we    <= bus.req_we;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_cnt   <= CNT_INIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rsp_valid <= 1'b1;
            r_err       <= !w_in_range;
            r_rdata     <= (w_in_range && !r_we) ? mem[w_idx] : '0;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Array is never reset; a reset before the access edge leaves r_state out of WAIT, dropping the write.
  always_ff @(posedge clk) begin
    if (w_access && r_we && w_in_range) mem[w_idx] <= r_wdata;
  end

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Directed bench: three responders (WAIT_CYCLES 2, 0, 7) sharing clock and reset.
module tb_mips32_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  tb_req_valid = '0;
  logic [2:0]  tb_req_we    = '0;
  logic [2:0]  tb_rsp_ready = '0;
  logic [31:0] tb_req_addr  [3];
  logic [31:0] tb_req_wdata [3];
  logic [2:0]  tb_req_ready;
  logic [2:0]  tb_rsp_valid;
  logic [2:0]  tb_rsp_err;
  logic [2:0]  tb_busy;
  logic [31:0] tb_rsp_rdata [3];

  int nchk  = 0;
  int npass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : G
    localparam int WC = (g == 0) ? 2 : ((g == 1) ? 0 : 7);
    mips32_mem_responder_if #(.DATA_W(32)) bus ();
    mips32_mem_responder #(.DEPTH(1024), .DATA_W(32), .WAIT_CYCLES(WC)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (tb_busy[g])
    );
    assign bus.req_valid    = tb_req_valid[g];
    assign bus.req_we       = tb_req_we[g];
    assign bus.req_addr     = tb_req_addr[g];
    assign bus.req_wdata    = tb_req_wdata[g];
    assign bus.rsp_ready    = tb_rsp_ready[g];
    assign tb_req_ready[g]  = bus.req_ready;
    assign tb_rsp_valid[g]  = bus.rsp_valid;
    assign tb_rsp_err[g]    = bus.rsp_err;
    assign tb_rsp_rdata[g]  = bus.rsp_rdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic accept(input int sel, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd);
    int   n   = 0;
    logic got = 1'b0;
    tb_req_we[sel]    = we;
    tb_req_addr[sel]  = addr;
    tb_req_wdata[sel] = wd;
    tb_req_valid[sel] = 1'b1;
    while (!got && n < 40) begin
      got = tb_req_ready[sel];
      @(posedge clk); #1;
      n++;
    end
    tb_req_valid[sel] = 1'b0;
    chk("accept", 32'(got), 32'd1);
  endtask

  task automatic do_req(input int sel, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic err, output int lat, output logic rdy_low);
    tb_rsp_ready[sel] = 1'b1;
    accept(sel, we, addr, wd);
    lat     = 0;
    rdy_low = 1'b1;
    while (!tb_rsp_valid[sel] && lat < 40) begin
      if (tb_req_ready[sel]) rdy_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (tb_req_ready[sel]) rdy_low = 1'b0;
    chk("rsp_seen", 32'(tb_rsp_valid[sel]), 32'd1);
    rd  = tb_rsp_rdata[sel];
    err = tb_rsp_err[sel];
    @(posedge clk); #1;
    chk("rsp_drop", 32'(tb_rsp_valid[sel]), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    logic        rl;
    int          lat;
    int          n;
    for (int i = 0; i < 3; i++) begin
      tb_req_addr[i]  = '0;
      tb_req_wdata[i] = '0;
    end

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", 32'(tb_req_ready[0]), 32'd1);
    chk("rst_busy",  32'(tb_busy[0]),      32'd0);
    chk("rst_valid", 32'(tb_rsp_valid[0]), 32'd0);

    // Write then read back, WAIT_CYCLES=2
    do_req(0, 1'b1, 32'd5, 32'hDEADBEEF, rd, err, lat, rl);
    chk("wr5_lat", 32'(lat), 32'd3);
    chk("wr5_err", 32'(err), 32'd0);
    chk("wr5_rd",  rd,       32'd0);
    chk("wr5_rdy", 32'(rl),  32'd1);
    do_req(0, 1'b0, 32'd5, 32'd0, rd, err, lat, rl);
    chk("rd5_data", rd,       32'hDEADBEEF);
    chk("rd5_err",  32'(err), 32'd0);

    // Latency sweep
    do_req(1, 1'b1, 32'd3, 32'h33, rd, err, lat, rl);
    chk("w0_lat", 32'(lat), 32'd1);
    chk("w0_rdy", 32'(rl),  32'd1);
    do_req(1, 1'b0, 32'd3, 32'd0, rd, err, lat, rl);
    chk("w0_rd", rd, 32'h33);
    do_req(2, 1'b1, 32'd4, 32'h44, rd, err, lat, rl);
    chk("w7_lat", 32'(lat), 32'd8);
    chk("w7_rdy", 32'(rl),  32'd1);
    do_req(2, 1'b0, 32'd4, 32'd0, rd, err, lat, rl);
    chk("w7_rd",  rd,       32'h44);
    chk("w7_rlat", 32'(lat), 32'd8);

    // Backpressure on the top legal address
    do_req(0, 1'b1, 32'd1023, 32'h12345678, rd, err, lat, rl);
    chk("w1023_err", 32'(err), 32'd0);
    tb_rsp_ready[0] = 1'b0;
    accept(0, 1'b0, 32'd1023, 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk("bp_valid0", 32'(tb_rsp_valid[0]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(tb_rsp_valid[0]), 32'd1);
      chk("bp_rdata", tb_rsp_rdata[0],      32'h12345678);
    end
    tb_rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_drop",  32'(tb_rsp_valid[0]), 32'd0);
    chk("bp_clr",   tb_rsp_rdata[0],      32'd0);
    chk("bp_ready", 32'(tb_req_ready[0]), 32'd1);

    // Range errors
    do_req(0, 1'b1, 32'd0, 32'hA5A5A5A5, rd, err, lat, rl);
    do_req(0, 1'b1, 32'd1024, 32'hFFFF0000, rd, err, lat, rl);
    chk("w1024_err", 32'(err), 32'd1);
    chk("w1024_rd",  rd,       32'd0);
    do_req(0, 1'b0, 32'd0, 32'd0, rd, err, lat, rl);
    chk("rd0_keep", rd,       32'hA5A5A5A5);
    chk("rd0_err",  32'(err), 32'd0);
    do_req(0, 1'b0, 32'h80000005, 32'd0, rd, err, lat, rl);
    chk("rdhi_err", 32'(err), 32'd1);
    chk("rdhi_rd",  rd,       32'd0);
    do_req(0, 1'b0, 32'hFFFFFFFF, 32'd0, rd, err, lat, rl);
    chk("rdff_err", 32'(err), 32'd1);
    do_req(0, 1'b0, 32'd1023, 32'd0, rd, err, lat, rl);
    chk("rd1023",     rd,       32'h12345678);
    chk("rd1023_err", 32'(err), 32'd0);

    // Reset during WAIT with counter at 1 drops the pending write
    do_req(0, 1'b1, 32'd9, 32'd0, rd, err, lat, rl);
    accept(0, 1'b1, 32'd9, 32'd1);
    @(posedge clk); #1;
    chk("wait_busy", 32'(tb_busy[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("wait_rst_busy", 32'(tb_busy[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_req(0, 1'b0, 32'd9, 32'd0, rd, err, lat, rl);
    chk("rd9_old", rd, 32'd0);

    // Requests while busy are ignored
    accept(0, 1'b0, 32'd5, 32'd0);
    tb_req_we[0]    = 1'b1;
    tb_req_addr[0]  = 32'd5;
    tb_req_wdata[0] = 32'h00000BAD;
    tb_req_valid[0] = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    tb_req_valid[0] = 1'b0;
    @(posedge clk); #1;
    chk("ign_valid", 32'(tb_rsp_valid[0]), 32'd1);
    chk("ign_rdata", tb_rsp_rdata[0],      32'hDEADBEEF);
    @(posedge clk); #1;
    n = 0;
    repeat (8) begin
      if (tb_rsp_valid[0]) n++;
      @(posedge clk); #1;
    end
    chk("ign_norsp", 32'(n), 32'd0);
    do_req(0, 1'b0, 32'd5, 32'd0, rd, err, lat, rl);
    chk("ign_mem", rd, 32'hDEADBEEF);

    // Mid-cycle reset while a read response is held
    tb_rsp_ready[0] = 1'b0;
    accept(0, 1'b0, 32'd5, 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk("resp_hold", tb_rsp_rdata[0], 32'hDEADBEEF);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(tb_rsp_valid[0]), 32'd0);
    chk("arst_rdata", tb_rsp_rdata[0],      32'd0);
    chk("arst_err",   32'(tb_rsp_err[0]),   32'd0);
    chk("arst_ready", 32'(tb_req_ready[0]), 32'd1);
    chk("arst_busy",  32'(tb_busy[0]),      32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset in RESP keeps a completed write
    accept(0, 1'b1, 32'd7, 32'h77);
    repeat (3) begin @(posedge clk); #1; end
    chk("w7_held", 32'(tb_rsp_valid[0]), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    do_req(0, 1'b0, 32'd7, 32'd0, rd, err, lat, rl);
    chk("rd7_kept", rd, 32'h77);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
